// File: rtl/lzs_pkg.sv
// Shared constants and types for the LZS decoder front end.
package lzs_pkg;
  localparam int LZS_BUF_W     = 64;
  localparam int LZS_WORD_W    = 16;
  localparam int LZS_REFILL_TH = 48;

  typedef logic [3:0] lzs_width_t;
endpackage

// File: rtl/lzs_bit_feeder_if.sv
// Word-in / bit-window-out handshake bundle between the word FIFO, bit feeder and decoder.
interface lzs_bit_feeder_if
  import lzs_pkg::*;
#(
  parameter int IN_WIDTH  = 13,
  parameter int LZF_WIDTH = 20
);
  logic                   wd_valid;
  logic [LZS_WORD_W-1:0]  wd_data;
  logic                   wd_last;
  logic                   wd_ready;
  logic                   stream_valid;
  logic [IN_WIDTH-1:0]    stream_data;
  logic                   stream_empty;
  logic                   stream_ack;
  lzs_width_t             stream_width;
  logic [LZF_WIDTH+3:0]   bits_used;
  logic                   err;

  // feeder side
  modport slave (
    input  wd_valid, wd_data, wd_last, stream_ack, stream_width,
    output wd_ready, stream_valid, stream_data, stream_empty, bits_used, err
  );

  // FIFO + decoder side
  modport master (
    output wd_valid, wd_data, wd_last, stream_ack, stream_width,
    input  wd_ready, stream_valid, stream_data, stream_empty, bits_used, err
  );
endinterface

// File: rtl/lzs_bit_shifter.sv
// Combinational barrel shift of the left-aligned bit buffer plus insertion of a new word
// directly behind the bits that remain after consuming w.
module lzs_bit_shifter
  import lzs_pkg::*;
(
  input  logic [LZS_BUF_W-1:0]  cur,
  input  logic [6:0]            left,
  input  lzs_width_t            w,
  input  logic [LZS_WORD_W-1:0] wd_data,
  input  logic                  acc,
  output logic [LZS_BUF_W-1:0]  nxt
);
  logic                 over;
  logic [6:0]           rem;
  logic [LZS_BUF_W-1:0] kept;
  logic [LZS_BUF_W-1:0] word_ext;

  // over-consumption discards the whole buffer rather than wrapping the shift
  assign over     = {3'b000, w} > left;
  assign rem      = over ? 7'd0 : left - {3'b000, w};
  assign kept     = over ? '0 : cur << w;
  assign word_ext = {wd_data, {(LZS_BUF_W-LZS_WORD_W){1'b0}}} >> rem;
  assign nxt      = kept | (acc ? word_ext : '0);
endmodule

// File: rtl/lzs_bit_feeder.sv
// LZS decoder bit feeder: packs 16-bit words into a 64-bit left-aligned buffer and
// presents an IN_WIDTH-bit look-ahead window, consuming stream_width bits per ack.
module lzs_bit_feeder
  import lzs_pkg::*;
#(
  parameter int IN_WIDTH  = 13,
  parameter int LZF_WIDTH = 20
)
(
  input  logic             clk,
  input  logic             rst_n,
  lzs_bit_feeder_if.slave  bus
);
  localparam int UW = LZF_WIDTH + 4;

  logic [LZS_BUF_W-1:0] buf_q;
  logic [LZS_BUF_W-1:0] buf_n;
  logic [6:0]           left_q;
  logic [6:0]           left_n;
  logic [6:0]           rem;
  logic                 eos_q;
  logic                 err_q;
  logic [UW-1:0]        used_q;
  logic                 ready;
  logic                 valid;
  logic                 ack_eff;
  logic                 acc;
  logic                 over;
  logic                 bad_ack;
  lzs_width_t           w;

  assign ready   = !eos_q && (left_q <= 7'(LZS_REFILL_TH));
  assign valid   = (left_q >= 7'(IN_WIDTH)) || (eos_q && left_q != 7'd0);
  assign ack_eff = bus.stream_ack && valid;
  assign w       = ack_eff ? bus.stream_width : '0;
  assign acc     = bus.wd_valid && ready;

  assign over    = {3'b000, w} > left_q;
  assign rem     = over ? 7'd0 : left_q - {3'b000, w};
  assign left_n  = rem + (acc ? 7'(LZS_WORD_W) : 7'd0);
  assign bad_ack = ack_eff && (({3'b000, bus.stream_width} > 7'(IN_WIDTH)) || over);

  lzs_bit_shifter u_shifter (
    .cur     (buf_q),
    .left    (left_q),
    .w       (w),
    .wd_data (bus.wd_data),
    .acc     (acc),
    .nxt     (buf_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      left_q <= '0;
      eos_q  <= 1'b0;
      used_q <= '0;
      err_q  <= 1'b0;
    end else begin
      buf_q  <= buf_n;
      left_q <= left_n;
      eos_q  <= eos_q | (acc & bus.wd_last);
      used_q <= used_q + UW'(w);
      // a word offered after end of stream is never accepted, only flagged
      err_q  <= err_q | bad_ack | (bus.wd_valid & eos_q);
    end
  end

  assign bus.wd_ready     = ready;
  assign bus.stream_valid = valid;
  assign bus.stream_data  = buf_q[LZS_BUF_W-1 -: IN_WIDTH];
  assign bus.stream_empty = eos_q && (left_q == 7'd0);
  assign bus.bits_used    = used_q;
  assign bus.err          = err_q;
endmodule
